add_seq_ctrl: RTL and testbench
===============================

# add_seq_ctrl

Controller that sequences the 8-bit adder datapath for the text-display calculator. It collects two operands from `data_in` on successive `next` strobes and performs a bit-serial add. It then converts operands and sum to ASCII and presents a 31-character line on `text_out` with `done` high. It sits between the debounced keypad/switch front end and the character display driver.

## Interface

**Parameters**
- `TEXT_CHARS`, default 31: width of `text_out` in characters; minimum 16.
- `PAD_CHAR`, default 8'h20: fill character for unused positions.

**Ports**
- `Clk`  in  1  system clock; all state changes on the rising edge.
- `Reset_n`  in  1  reset, synchronous, active-low.
- `data_in`  in  8  operand value, sampled only on a `next` cycle in S_A or S_B.
- `next`  in  1  single-cycle strobe, already debounced upstream.
- `text_out`  out  8*TEXT_CHARS  ASCII line; char i is at bits [8*TEXT_CHARS-1-8i -: 8], with i=0 leftmost.
- `sum`  out  9  registered binary sum.
- `busy`  out  1  high in S_ADD, S_CVA, S_CVB, S_CVS and S_FMT.
- `done`  out  1  high throughout S_DONE.

## Operation

**States**
- S_A: on `next`, latch A=`data_in` → S_B.
- S_B: on `next`, latch B=`data_in`, clear carry and bit counter → S_ADD.
- S_ADD: 8 cycles, one bit per cycle, LSB first. sum[i] = A[i]^B[i]^c and c ← majority(A[i], B[i], c). After bit 7, sum[8]=c → S_CVA.
- S_CVA, S_CVB, S_CVS: each runs one 10-cycle binary-to-BCD conversion, of A, B and sum respectively → next state.
- S_FMT: 1 cycle; writes `text_out` → S_DONE.
- S_DONE: holds `done` and `text_out`. On `next`, `text_out` is reset to all PAD_CHAR, A and B are cleared → S_A.

**Arithmetic and format**
- Sum is 9-bit unsigned, no overflow possible: 255+255 = 510.
- Decimal line is "AAA + BBB = SSSS" in chars 0-15, leading zeros kept. Chars 16..TEXT_CHARS-1 are PAD_CHAR.

**Boundary conditions**
- `next` in any busy state is ignored; it is not queued.
- `data_in` changes outside a `next` cycle have no effect.
- `Reset_n` low at any edge, including mid-add or mid-conversion, forces every register to its reset value at that edge.

## Timing

- Reset values: state S_A, `done`=0, `busy`=0, `sum`=0, `text_out` all PAD_CHAR, A=B=0.
- B is latched at edge k. S_ADD covers edges k+1..k+8. S_CVA ends at k+18, S_CVB at k+28, S_CVS at k+38. S_FMT runs at k+39, and `done` and `text_out` are valid at edge k+39.
- `busy` rises at edge k and falls at edge k+39.
- `sum` is final at edge k+8.
- After the `next` strobe in S_DONE, `done` falls at the following edge.

## Configuration

- `ADD_SEQ_HEX_EN` defined: the S_CV* states and the converter are not instantiated. S_ADD goes directly to S_FMT. Line is "HH + HH = HHH" in chars 0-12, uppercase hex digits. `done` is valid at edge k+9.
- `ADD_SEQ_HEX_EN` undefined: decimal behaviour as described above.

## Structure

- Shared package `add_seq_pkg` holds:
  - the state encoding (S_A, S_B, S_ADD, S_CVA, S_CVB, S_CVS, S_FMT, S_DONE);
  - ASCII constants for '0', 'A', '+', '=' and space;
  - the default `TEXT_CHARS`;
  - the digit-to-ASCII function.
- Sub-module `bin2bcd_seq` implements the converter:
  - 9-bit input, 12-bit BCD output, shift-add-3 (double dabble).
  - `start` loads the input at cycle 0; 9 shift cycles follow; `valid` is high on cycle 10.
  - The controller reuses one instance for all three conversions.

## Test plan

- Enter 123, then 45 → at k+39, chars 0-15 = "123 + 045 = 0168", `sum`=168, `done`=1, chars 16-30 = 0x20.
- Enter 255, then 255 → "255 + 255 = 0510", `sum`=9'h1FE.
- Enter 0, then 0 → "000 + 000 = 0000"; `busy` is high for exactly 39 cycles.
- `next` pulses at k+3 and k+20 → ignored; result is unchanged and `done` still rises at k+39. A `next` in S_DONE → `done`=0 and `text_out` all 0x20 at the next edge.
- `Reset_n`=0 at k+5 → at that edge: state S_A, `sum`=0, `busy`=0, `text_out` all 0x20. A following 7+8 completes normally with "007 + 008 = 0015".
- With `ADD_SEQ_HEX_EN`: 8'h7B + 8'h2D → "7B + 2D = 0A8" at k+9.

Source files
------------

// File: rtl/add_seq_pkg.sv
// Shared definitions for the adder sequencing controller: state encoding,
// ASCII constants, default line width and the digit-to-ASCII helper.
package add_seq_pkg;

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_ADD  = 3'd2,
        S_CVA  = 3'd3,
        S_CVB  = 3'd4,
        S_CVS  = 3'd5,
        S_FMT  = 3'd6,
        S_DONE = 3'd7
    } state_t;

    localparam logic [7:0] ASC_ZERO    = 8'h30;
    localparam logic [7:0] ASC_UPPER_A = 8'h41;
    localparam logic [7:0] ASC_PLUS    = 8'h2B;
    localparam logic [7:0] ASC_EQUAL   = 8'h3D;
    localparam logic [7:0] ASC_SPACE   = 8'h20;

    localparam int TEXT_CHARS_DEF = 31;

    // Number of shift cycles after the load cycle of the BCD converter.
    localparam logic [3:0] BCD_SHIFTS = 4'd9;

    // Hex/decimal digit to ASCII; values 10..15 map to uppercase letters.
    function automatic logic [7:0] digit_to_ascii(input logic [3:0] d);
        if (d < 4'd10) begin
            return ASC_ZERO + {4'd0, d};
        end
        return ASC_UPPER_A + {4'd0, d} - 8'd10;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 9-bit binary to 3-digit BCD converter (shift-add-3).
// start loads the operand; nine shift cycles follow; valid is high once the
// last shift has landed and stays high until the next start.
module bin2bcd_seq
    import add_seq_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        start,
    input  logic [8:0]  bin,
    output logic [11:0] bcd,
    output logic        valid
);

    // {bcd[11:0], bin[8:0]} working register
    logic [20:0] sh_q, sh_d, adj;
    logic [3:0]  cnt_q, cnt_d;
    logic        loaded_q, loaded_d;

    // Load on start, otherwise adjust digits >= 5 and shift while cycles remain.
    always_comb begin
        sh_d     = sh_q;
        cnt_d    = cnt_q;
        loaded_d = loaded_q;
        adj      = sh_q;
        if (start) begin
            sh_d     = {12'd0, bin};
            cnt_d    = BCD_SHIFTS;
            loaded_d = 1'b1;
        end else if (cnt_q != 4'd0) begin
            for (int d = 0; d < 3; d++) begin
                if (adj[9 + 4*d +: 4] >= 4'd5) begin
                    adj[9 + 4*d +: 4] = adj[9 + 4*d +: 4] + 4'd3;
                end
            end
            sh_d  = {adj[19:0], 1'b0};
            cnt_d = cnt_q - 4'd1;
        end
    end

    // Converter state register with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            sh_q     <= '0;
            cnt_q    <= '0;
            loaded_q <= 1'b0;
        end else begin
            sh_q     <= sh_d;
            cnt_q    <= cnt_d;
            loaded_q <= loaded_d;
        end
    end

    assign bcd   = sh_q[20:9];
    assign valid = loaded_q && (cnt_q == 4'd0);

endmodule

// File: rtl/add_seq_ctrl.sv
// Adder sequencing controller for the text-display calculator.
// Collects A and B on next strobes, adds them bit-serially, converts to
// ASCII and presents "AAA + BBB = SSSS" on text_out with done high.
// Build option ADD_SEQ_HEX_EN: skip BCD conversion, print "HH + HH = HHH".
//
//   state  | meaning
//   S_A    | wait for next, latch A
//   S_B    | wait for next, latch B, clear carry/bit counter
//   S_ADD  | 8 cycles, one sum bit per cycle, LSB first
//   S_CVA  | 10-cycle BCD conversion of A
//   S_CVB  | 10-cycle BCD conversion of B (captures A's digits)
//   S_CVS  | 10-cycle BCD conversion of sum (captures B's digits)
//   S_FMT  | write text line
//   S_DONE | hold result until next, then clear and return to S_A
module add_seq_ctrl
    import add_seq_pkg::*;
#(
    parameter int         TEXT_CHARS = TEXT_CHARS_DEF,
    parameter logic [7:0] PAD_CHAR   = 8'h20
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic [7:0]              data_in,
    input  logic                    next,
    output logic [8*TEXT_CHARS-1:0] text_out,
    output logic [8:0]              sum,
    output logic                    busy,
    output logic                    done
);

    localparam int TW = 8*TEXT_CHARS;

    state_t          state_q, state_d;
    logic [7:0]      a_q, a_d, b_q, b_d;
    logic [8:0]      sum_q, sum_d;
    logic            carry_q, carry_d, maj;
    logic [2:0]      bit_q, bit_d;
    logic [TW-1:0]   text_q, text_d, fmt_line;
    logic [7:0]      fmt_chars [16];

`ifndef ADD_SEQ_HEX_EN
    logic [3:0]      tmr_q, tmr_d;
    logic [11:0]     bcd_a_q, bcd_a_d, bcd_b_q, bcd_b_d;
    logic            conv_start, conv_valid;
    logic [8:0]      conv_in;
    logic [11:0]     conv_bcd;

    bin2bcd_seq u_bin2bcd (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .start   (conv_start),
        .bin     (conv_in),
        .bcd     (conv_bcd),
        .valid   (conv_valid)
    );
`endif

    assign maj = (a_q[bit_q] & b_q[bit_q]) | (a_q[bit_q] & carry_q) | (b_q[bit_q] & carry_q);

    // Assemble the result line from the captured operands and final sum.
    always_comb begin
        for (int i = 0; i < 16; i++) fmt_chars[i] = PAD_CHAR;
        fmt_chars[3] = ASC_PLUS;
        fmt_chars[4] = ASC_SPACE;
`ifdef ADD_SEQ_HEX_EN
        fmt_chars[0]  = digit_to_ascii(a_q[7:4]);
        fmt_chars[1]  = digit_to_ascii(a_q[3:0]);
        fmt_chars[2]  = ASC_SPACE;
        fmt_chars[5]  = digit_to_ascii(b_q[7:4]);
        fmt_chars[6]  = digit_to_ascii(b_q[3:0]);
        fmt_chars[7]  = ASC_SPACE;
        fmt_chars[8]  = ASC_EQUAL;
        fmt_chars[9]  = ASC_SPACE;
        fmt_chars[10] = digit_to_ascii({3'd0, sum_q[8]});
        fmt_chars[11] = digit_to_ascii(sum_q[7:4]);
        fmt_chars[12] = digit_to_ascii(sum_q[3:0]);
`else
        fmt_chars[0]  = digit_to_ascii(bcd_a_q[11:8]);
        fmt_chars[1]  = digit_to_ascii(bcd_a_q[7:4]);
        fmt_chars[2]  = digit_to_ascii(bcd_a_q[3:0]);
        fmt_chars[3]  = ASC_SPACE;
        fmt_chars[4]  = ASC_PLUS;
        fmt_chars[5]  = ASC_SPACE;
        fmt_chars[6]  = digit_to_ascii(bcd_b_q[11:8]);
        fmt_chars[7]  = digit_to_ascii(bcd_b_q[7:4]);
        fmt_chars[8]  = digit_to_ascii(bcd_b_q[3:0]);
        fmt_chars[9]  = ASC_SPACE;
        fmt_chars[10] = ASC_EQUAL;
        fmt_chars[11] = ASC_SPACE;
        // Sum never exceeds 510, so the thousands digit is always zero.
        fmt_chars[12] = ASC_ZERO;
        fmt_chars[13] = digit_to_ascii(conv_bcd[11:8]);
        fmt_chars[14] = digit_to_ascii(conv_bcd[7:4]);
        fmt_chars[15] = digit_to_ascii(conv_bcd[3:0]);
`endif
        fmt_line = {TEXT_CHARS{PAD_CHAR}};
        for (int i = 0; i < 16; i++) fmt_line[TW-1-8*i -: 8] = fmt_chars[i];
    end

    // Next-state and datapath update for every state.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        bit_d   = bit_q;
        text_d  = text_q;
`ifndef ADD_SEQ_HEX_EN
        tmr_d      = tmr_q;
        bcd_a_d    = bcd_a_q;
        bcd_b_d    = bcd_b_q;
        conv_start = 1'b0;
        conv_in    = {1'b0, a_q};
`endif
        case (state_q)
            S_A: if (next) begin
                a_d     = data_in;
                state_d = S_B;
            end
            S_B: if (next) begin
                b_d     = data_in;
                carry_d = 1'b0;
                bit_d   = 3'd0;
                state_d = S_ADD;
            end
            S_ADD: begin
                sum_d[bit_q] = a_q[bit_q] ^ b_q[bit_q] ^ carry_q;
                carry_d      = maj;
                bit_d        = bit_q + 3'd1;
                if (bit_q == 3'd7) begin
                    sum_d[8] = maj;
`ifdef ADD_SEQ_HEX_EN
                    state_d  = S_FMT;
`else
                    state_d  = S_CVA;
                    tmr_d    = BCD_SHIFTS;
`endif
                end
            end
`ifndef ADD_SEQ_HEX_EN
            // Each conversion state starts the converter on its first cycle and
            // picks up the previous conversion's digits on that same cycle.
            S_CVA, S_CVB, S_CVS: begin
                conv_start = (tmr_q == BCD_SHIFTS);
                if (state_q == S_CVB) conv_in = {1'b0, b_q};
                if (state_q == S_CVS) conv_in = sum_q;
                if (conv_start && conv_valid) begin
                    if (state_q == S_CVB) bcd_a_d = conv_bcd;
                    if (state_q == S_CVS) bcd_b_d = conv_bcd;
                end
                tmr_d = tmr_q - 4'd1;
                if (tmr_q == 4'd0) begin
                    tmr_d = BCD_SHIFTS;
                    case (state_q)
                        S_CVA:   state_d = S_CVB;
                        S_CVB:   state_d = S_CVS;
                        default: state_d = S_FMT;
                    endcase
                end
            end
`endif
            S_FMT: begin
                text_d  = fmt_line;
                state_d = S_DONE;
            end
            S_DONE: if (next) begin
                text_d  = {TEXT_CHARS{PAD_CHAR}};
                a_d     = 8'd0;
                b_d     = 8'd0;
                state_d = S_A;
            end
            default: state_d = S_A;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= S_A;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            bit_q   <= '0;
            text_q  <= {TEXT_CHARS{PAD_CHAR}};
`ifndef ADD_SEQ_HEX_EN
            tmr_q   <= '0;
            bcd_a_q <= '0;
            bcd_b_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            bit_q   <= bit_d;
            text_q  <= text_d;
`ifndef ADD_SEQ_HEX_EN
            tmr_q   <= tmr_d;
            bcd_a_q <= bcd_a_d;
            bcd_b_q <= bcd_b_d;
`endif
        end
    end

    assign text_out = text_q;
    assign sum      = sum_q;
    assign busy     = (state_q == S_ADD) || (state_q == S_CVA) || (state_q == S_CVB) ||
                      (state_q == S_CVS) || (state_q == S_FMT);
    assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Self-checking bench for add_seq_ctrl: table of directed operand pairs,
// reset-during-add sequence, and randomized operand pairs against a
// string-formatting reference model.
module tb_add_seq_ctrl;

    localparam int TC = 31;
    localparam int TW = 8*TC;
`ifdef ADD_SEQ_HEX_EN
    localparam int LAT = 9;
`else
    localparam int LAT = 39;
`endif

    logic          Clk = 1'b0;
    logic          Reset_n;
    logic [7:0]    data_in;
    logic          next;
    logic [TW-1:0] text_out;
    logic [8:0]    sum;
    logic          busy;
    logic          done;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int a;
        int b;
        int inject;
        int exp_sum;
    } vec_t;

    vec_t vecs [6];

    add_seq_ctrl dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .data_in  (data_in),
        .next     (next),
        .text_out (text_out),
        .sum      (sum),
        .busy     (busy),
        .done     (done)
    );

    always #5 Clk = ~Clk;

    function automatic logic [TW-1:0] pad_line();
        return {TC{8'h20}};
    endfunction

    // Reference line built directly from the printed form of the arithmetic.
    function automatic logic [TW-1:0] model_line(input int a, input int b);
        string s;
        logic [TW-1:0] r;
`ifdef ADD_SEQ_HEX_EN
        s = $sformatf("%02X + %02X = %03X", a, b, a + b);
`else
        s = $sformatf("%03d + %03d = %04d", a, b, a + b);
`endif
        r = pad_line();
        for (int i = 0; i < s.len(); i++) r[TW-1-8*i -: 8] = s[i];
        return r;
    endfunction

    task automatic check(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_op(input int a, input int b, input int inject, input int exp_sum, input string tag);
        int n;
        int busy_cycles;
        logic [TW-1:0] exp_line;
        exp_line = model_line(a, b);
        // data_in wiggling with no strobe must not matter
        repeat (2) begin
            data_in = 8'($urandom);
            @(negedge Clk);
        end
        data_in = 8'(a);
        next    = 1'b1;
        @(negedge Clk);
        next    = 1'b0;
        data_in = 8'($urandom);
        @(negedge Clk);
        data_in = 8'(b);
        next    = 1'b1;
        @(posedge Clk);                 // edge k
        @(negedge Clk);
        next        = 1'b0;
        n           = 0;
        busy_cycles = 0;
        while (!done && n < 200) begin
            if (busy) busy_cycles++;
            if (n == 8) check({tag, " sum@k+8"}, TW'(sum), TW'(exp_sum));
            data_in = 8'($urandom);
            next    = (inject != 0) && (n == 2 || n == 19);
            @(negedge Clk);
            n++;
        end
        next = 1'b0;
        check({tag, " done latency"}, TW'(n), TW'(LAT));
        check({tag, " busy cycles"}, TW'(busy_cycles), TW'(LAT));
        check({tag, " text"}, text_out, exp_line);
        check({tag, " sum"}, TW'(sum), TW'(exp_sum));
        check({tag, " busy low at done"}, TW'(busy), TW'(0));
        @(negedge Clk);
        check({tag, " done held"}, TW'(done), TW'(1));
        check({tag, " text held"}, text_out, exp_line);
        next = 1'b1;
        @(negedge Clk);
        next = 1'b0;
        check({tag, " done cleared"}, TW'(done), TW'(0));
        check({tag, " text cleared"}, text_out, pad_line());
    endtask

    initial begin
        int ra;
        int rb;
        vecs = '{
            '{123,  45, 0, 168},
            '{255, 255, 0, 510},
            '{  0,   0, 0,   0},
            '{123,  45, 1, 168},
            '{200,  17, 1, 217},
            '{  9, 250, 0, 259}
        };

        Reset_n = 1'b0;
        next    = 1'b0;
        data_in = 8'd0;
        repeat (3) @(negedge Clk);
        check("reset sum", TW'(sum), TW'(0));
        check("reset busy", TW'(busy), TW'(0));
        check("reset done", TW'(done), TW'(0));
        check("reset text", text_out, pad_line());
        Reset_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].inject, vecs[i].exp_sum, $sformatf("vec%0d", i));
        end

        // Reset asserted so that it is sampled at edge k+5, mid-add.
        @(negedge Clk);
        data_in = 8'd200;
        next    = 1'b1;
        @(negedge Clk);
        next    = 1'b0;
        @(negedge Clk);
        data_in = 8'd100;
        next    = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        next = 1'b0;
        repeat (4) @(negedge Clk);
        check("pre-reset busy", TW'(busy), TW'(1));
        Reset_n = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        check("midadd reset busy", TW'(busy), TW'(0));
        check("midadd reset done", TW'(done), TW'(0));
        check("midadd reset sum", TW'(sum), TW'(0));
        check("midadd reset text", text_out, pad_line());
        run_op(7, 8, 0, 15, "after reset");

        for (int i = 0; i < 12; i++) begin
            ra = int'($urandom_range(255, 0));
            rb = int'($urandom_range(255, 0));
            run_op(ra, rb, int'($urandom_range(1, 0)), ra + rb, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
